// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its BTB.
package fetch_pkg;

  // Widest address the BTB entry storage supports; narrower cores zero-extend.
  localparam int XLEN = 32;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] target;
    ctr_e            ctr;
  } btb_entry_t;

  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    case (c)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      ST:      n = taken ? ST  : WT;
      default: n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fetch_stage_bp_btb.sv
// Direct-mapped branch target buffer: combinational lookup, one update port.
// Addresses arrive as word addresses (byte offset already dropped).
module btb
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BTB_ENTRIES   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-3:0] rd_word,
  output logic                     rd_taken,
  output logic [ADDRESS_WIDTH-1:0] rd_target,
  input  logic                     upd_en,
  input  logic [ADDRESS_WIDTH-3:0] upd_word,
  input  logic [ADDRESS_WIDTH-1:0] upd_target,
  input  logic                     upd_taken
);

  localparam int IDX = $clog2(BTB_ENTRIES);

  btb_entry_t entry_q [BTB_ENTRIES];
  btb_entry_t entry_d [BTB_ENTRIES];

  logic [IDX-1:0]  rd_idx;
  logic [XLEN-1:0] rd_tag;
  btb_entry_t      rd_entry;
  logic            rd_hit;

  logic [IDX-1:0]  upd_idx;
  logic [XLEN-1:0] upd_tag;
  btb_entry_t      upd_entry;
  logic            upd_hit;
  logic            wr_en;
  btb_entry_t      wr_entry;

  always_comb begin
    rd_idx    = rd_word[IDX-1:0];
    rd_tag    = XLEN'(rd_word[ADDRESS_WIDTH-3:IDX]);
    rd_entry  = entry_q[rd_idx];
    rd_hit    = rd_entry.valid && (rd_entry.tag == rd_tag);
    rd_taken  = rd_hit && rd_entry.ctr[1];
    rd_target = rd_entry.target[ADDRESS_WIDTH-1:0];
  end

  // A hit trains the counter; a taken miss evicts whatever shares the index.
  always_comb begin
    upd_idx   = upd_word[IDX-1:0];
    upd_tag   = XLEN'(upd_word[ADDRESS_WIDTH-3:IDX]);
    upd_entry = entry_q[upd_idx];
    upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);
    wr_en     = 1'b0;
    wr_entry  = upd_entry;
    if (upd_en) begin
      if (upd_hit) begin
        wr_en        = 1'b1;
        wr_entry.ctr = ctr_next(upd_entry.ctr, upd_taken);
        if (upd_taken) begin
          wr_entry.target = XLEN'(upd_target);
        end
      end else if (upd_taken) begin
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = upd_tag;
        wr_entry.target = XLEN'(upd_target);
        wr_entry.ctr    = WT;
      end
    end
  end

  always_comb begin
    entry_d = entry_q;
    if (wr_en) begin
      entry_d[upd_idx] = wr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/fetch_stage_bp.sv
// RV32I fetch stage: PC register, next-PC selection with BTB prediction,
// and the IF/ID pipeline register feeding decode.
module fetch_stage_bp
  import fetch_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     DATA_WIDTH    = 32,
  parameter int                     BTB_ENTRIES   = 16,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     StallF,
  input  logic                     StallD,
  input  logic                     FlushD,
  input  logic                     PCSrcE,
  input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
  input  logic                     BtbUpdE,
  input  logic [ADDRESS_WIDTH-1:0] BtbPcE,
  input  logic [ADDRESS_WIDTH-1:0] BtbTargetE,
  input  logic                     BtbTakenE,
  output logic [ADDRESS_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0]    instr_in,
  output logic [DATA_WIDTH-1:0]    InstrD,
  output logic [ADDRESS_WIDTH-1:0] PCD,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
  output logic                     PredTakenD,
  output logic                     ValidD
);

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic                     pred_taken;
  logic [ADDRESS_WIDTH-1:0] pred_target;

  logic [DATA_WIDTH-1:0]    instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] pcd_q, pcd_d;
  logic [ADDRESS_WIDTH-1:0] pcp4d_q, pcp4d_d;
  logic                     predd_q, predd_d;
  logic                     validd_q, validd_d;

  // Instructions are word aligned, so the byte offset never reaches the BTB.
  logic btb_pc_unused;
  assign btb_pc_unused = ^BtbPcE[1:0];

  btb #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .BTB_ENTRIES   (BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .rd_word    (pc_q[ADDRESS_WIDTH-1:2]),
    .rd_taken   (pred_taken),
    .rd_target  (pred_target),
    .upd_en     (BtbUpdE),
    .upd_word   (BtbPcE[ADDRESS_WIDTH-1:2]),
    .upd_target (BtbTargetE),
    .upd_taken  (BtbTakenE)
  );

  assign pc_plus4   = pc_q + ADDRESS_WIDTH'(4);
  assign instr_addr = pc_q;

  // Redirect outranks the stall so a mispredict is never lost behind a hazard.
  always_comb begin
    pc_d = pc_plus4;
    if (PCSrcE) begin
      pc_d = PCTargetE;
    end else if (StallF) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  always_comb begin
    instr_d  = instr_q;
    pcd_d    = pcd_q;
    pcp4d_d  = pcp4d_q;
    predd_d  = predd_q;
    validd_d = validd_q;
    if (FlushD) begin
      instr_d  = DATA_WIDTH'(NOP);
      pcd_d    = '0;
      pcp4d_d  = '0;
      predd_d  = 1'b0;
      validd_d = 1'b0;
    end else if (!StallD) begin
      instr_d  = instr_in;
      pcd_d    = pc_q;
      pcp4d_d  = pc_plus4;
      predd_d  = pred_taken;
      validd_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      instr_q  <= DATA_WIDTH'(NOP);
      pcd_q    <= '0;
      pcp4d_q  <= '0;
      predd_q  <= 1'b0;
      validd_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcd_q    <= pcd_d;
      pcp4d_q  <= pcp4d_d;
      predd_q  <= predd_d;
      validd_q <= validd_d;
    end
  end

  assign InstrD     = instr_q;
  assign PCD        = pcd_q;
  assign PCPlus4D   = pcp4d_q;
  assign PredTakenD = predd_q;
  assign ValidD     = validd_q;

endmodule

// File: doc/fetch_stage_bp.md
# fetch_stage_bp

Parametrised instruction-fetch stage for the pipelined RV32I core with a direct-mapped branch target buffer (BTB) and an IF/ID pipeline register. It owns the PC register and next-PC selection: execute-stage redirect, stall hold, BTB-predicted target, or PC+4. Each fetched instruction is registered into the decode stage with its PC, PC+4 and prediction bit. It sits between the hazard unit / execute stage and the decode stage, and drives the address of the combinational instruction memory.

## Interface
- ADDRESS_WIDTH, 32, PC and target width
- DATA_WIDTH, 32, instruction width
- BTB_ENTRIES, 16, BTB depth; power of two, 2..256
- RESET_PC, 32'h0, PC value loaded on reset

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- StallF  in  1  hold PCF
- StallD  in  1  hold IF/ID register
- FlushD  in  1  load bubble into IF/ID register
- PCSrcE  in  1  execute redirect (mispredict or unpredicted taken)
- PCTargetE  in  ADDRESS_WIDTH  correct next PC on redirect
- BtbUpdE  in  1  a branch/jump resolved in execute this cycle
- BtbPcE  in  ADDRESS_WIDTH  PC of resolved instruction
- BtbTargetE  in  ADDRESS_WIDTH  resolved target
- BtbTakenE  in  1  actual outcome
- instr_addr  out  ADDRESS_WIDTH  equals PCF; drives instruction memory
- instr_in  in  DATA_WIDTH  instruction memory read data, same cycle
- InstrD  out  DATA_WIDTH  registered instruction
- PCD, PCPlus4D  out  ADDRESS_WIDTH  registered PC and PC+4
- PredTakenD  out  1  BTB predicted taken for InstrD
- ValidD  out  1  IF/ID holds a real instruction

## Operation
- IDX = log2(BTB_ENTRIES). Index = PCF[IDX+1:2]. Tag = PCF[ADDRESS_WIDTH-1:IDX+2].
- Each BTB entry holds a valid bit, a tag, a target and a 2-bit saturating counter.
- Lookup is combinational. Hit = valid && tag match. PredTakenF = hit && ctr[1].
- Next PC, in priority order:
  - PCSrcE → PCTargetE. This wins even when StallF is high.
  - StallF → PCF.
  - PredTakenF → entry target.
  - Otherwise → PCF+4. Addition is modulo 2^ADDRESS_WIDTH and wraps silently.
- BTB update when BtbUpdE is high, indexed and tagged from BtbPcE:
  - Tag hit: set the counter to ctr+1 if taken, ctr−1 if not taken, saturating at 3 and 0. Overwrite the target with BtbTargetE when taken.
  - Miss and taken: allocate. Set valid=1, write tag and target, ctr=2'b10.
  - Miss and not taken: no write.
- IF/ID register, in priority order:
  - FlushD → bubble: InstrD=NOP (32'h00000013), ValidD=0, PredTakenD=0, PCD=0, PCPlus4D=0.
  - StallD → hold all fields.
  - Otherwise → capture instr_in, PCF, PCF+4, PredTakenF, and set ValidD=1.
- The hazard unit asserts FlushD on PCSrcE. This block does not self-flush.

## Timing
- Reset (asynchronous, immediate):
  - PCF=RESET_PC, so instr_addr=RESET_PC.
  - All BTB valid bits=0. Targets and counters are don't-care.
  - IF/ID is loaded with the bubble values listed above.
- Release of reset: the first rising edge loads PCF+4 (BTB empty) and registers the instruction at RESET_PC into decode.
- Latency: instruction at PCF appears on InstrD 1 cycle later.
- A redirect at edge N makes PCF=PCTargetE after edge N.
- A BTB write at edge N is visible to the lookup from cycle N+1.
- Same-cycle update and lookup of the same index: the lookup sees the old contents.
- Reset asserted mid-operation: all state returns to reset values within the same cycle. Any pending update is discarded.
- FlushD and StallD together: the flush wins.

## Structure
- Package fetch_pkg holds:
  - NOP constant.
  - btb_entry_t struct {valid, tag, target, ctr}.
  - Counter encodings: SNT=00, WNT=01, WT=10, ST=11.
- Sub-module btb holds the entry array, combinational lookup port, one write port and the update/allocation logic.
- The top module holds the PC register, next-PC mux and IF/ID register.

## Test plan
- Reset with RESET_PC=0, no stalls, memory returns sequential words:
  - instr_addr runs 0,4,8,…; InstrD lags by 1 cycle.
  - ValidD=0 during reset, 1 afterwards.
- Loop branch:
  - BtbUpdE with BtbPcE=0x10, BtbTargetE=0x04, taken.
  - On the next fetch of 0x10, PredTakenF=1 and the PC after 0x10 is 0x04.
  - Two not-taken updates take ctr 10→01→00, and prediction turns off after the first.
- Redirect with StallF=1:
  - PCSrcE=1, PCTargetE=0x80.
  - PCF=0x80 next cycle despite the stall.
- StallD=1 for 3 cycles: InstrD, PCD and ValidD are held. FlushD=1 → InstrD=0x00000013, ValidD=0.
- Aliasing with BTB_ENTRIES=16:
  - Allocate PC 0x10, then look up 0x50 (same index, different tag) → no prediction.
  - A taken update at 0x50 replaces the entry, after which 0x10 misses.
- Asynchronous reset pulse mid-cycle: PCF becomes RESET_PC before the next edge and all BTB entries are invalid.
